// File: rtl/barrel_shift_pipe_if.sv
// Stream bundle for the pipelined barrel shifter: operand side (in_*)
// and result side (out_*), each with its own valid/ready pair.
interface barrel_shift_pipe_if #(
    parameter int WIDTH = 8
);
    localparam int SHA_BITS = $clog2(WIDTH);

    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_data;
    logic [SHA_BITS-1:0] in_sha;
    logic                in_dir;
    logic [1:0]          in_mode;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_data;
    logic                out_zero;

    modport master (
        output in_valid, in_data, in_sha, in_dir, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_sha, in_dir, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_zero
    );
endinterface

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter/rotator. Stage k conditionally shifts by 2^k,
// consuming the low bit of the remaining shift amount it receives. The
// whole pipe freezes when the output beat is blocked downstream.
module barrel_shift_pipe #(
    parameter  int WIDTH    = 8,
    localparam int SHA_BITS = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    barrel_shift_pipe_if.slave bus
);
    localparam int LAST = SHA_BITS - 1;

    // Inputs seen by each stage: stage 0 from the bus, others from the
    // previous stage's registers.
    logic [WIDTH-1:0]    src_data  [SHA_BITS];
    logic [SHA_BITS-1:0] src_sha   [SHA_BITS];
    logic                src_dir   [SHA_BITS];
    logic [1:0]          src_mode  [SHA_BITS];
    logic                src_sign  [SHA_BITS];
    logic                src_valid [SHA_BITS];

    // Per-stage registers; control only needs to reach the last stage's
    // input, so the last stage keeps data and valid only.
    logic [WIDTH-1:0]    stage_data  [SHA_BITS];
    logic                stage_valid [SHA_BITS];
    logic [SHA_BITS-1:0] stage_sha   [LAST];
    logic                stage_dir   [LAST];
    logic [1:0]          stage_mode  [LAST];
    logic                stage_sign  [LAST];

    logic [WIDTH-1:0]    next_data [SHA_BITS];
    logic                stall;

    // One stage step by a fixed power-of-two amount. Arithmetic fill uses
    // the original operand sign, not the current MSB, so it stays correct
    // after earlier stages have already moved bits around.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input int               amt,
        input logic             dir,
        input logic [1:0]       mode,
        input logic             sign
    );
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] r;
        ones = '1;
        if (mode[1]) begin
            r = dir ? ((d >> amt) | (d << (WIDTH - amt)))
                    : ((d << amt) | (d >> (WIDTH - amt)));
        end else if (dir) begin
            r = d >> amt;
            if (mode[0] && sign) begin
                r = r | ~(ones >> amt);
            end
        end else begin
            r = d << amt;
        end
        return r;
    endfunction

    assign stall        = stage_valid[LAST] && !bus.out_ready;
    assign bus.in_ready = !stall;
    assign bus.out_valid = stage_valid[LAST];
    assign bus.out_data  = stage_data[LAST];
    assign bus.out_zero  = stage_valid[LAST] && (stage_data[LAST] == '0);

    assign src_data[0]  = bus.in_data;
    assign src_sha[0]   = bus.in_sha;
    assign src_dir[0]   = bus.in_dir;
    assign src_mode[0]  = bus.in_mode;
    assign src_sign[0]  = bus.in_data[WIDTH-1];
    assign src_valid[0] = bus.in_valid;

    for (genvar k = 1; k < SHA_BITS; k++) begin : g_link
        assign src_data[k]  = stage_data[k-1];
        assign src_sha[k]   = stage_sha[k-1];
        assign src_dir[k]   = stage_dir[k-1];
        assign src_mode[k]  = stage_mode[k-1];
        assign src_sign[k]  = stage_sign[k-1];
        assign src_valid[k] = stage_valid[k-1];
    end

    // Each stage applies its 2^k step when the low remaining sha bit is set.
    always_comb begin
        for (int k = 0; k < SHA_BITS; k++) begin
            next_data[k] = src_data[k];
            if (src_sha[k][0]) begin
                next_data[k] = shift_step(src_data[k], 1 << k, src_dir[k],
                                          src_mode[k], src_sign[k]);
            end
        end
    end

    // Advance every stage together unless the output is blocked; reset
    // drops all in-flight beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SHA_BITS; k++) begin
                stage_valid[k] <= 1'b0;
                stage_data[k]  <= '0;
            end
            for (int k = 0; k < LAST; k++) begin
                stage_sha[k]  <= '0;
                stage_dir[k]  <= 1'b0;
                stage_mode[k] <= 2'b00;
                stage_sign[k] <= 1'b0;
            end
        end else if (!stall) begin
            for (int k = 0; k < SHA_BITS; k++) begin
                stage_valid[k] <= src_valid[k];
                stage_data[k]  <= next_data[k];
            end
            for (int k = 0; k < LAST; k++) begin
                stage_sha[k]  <= src_sha[k] >> 1;
                stage_dir[k]  <= src_dir[k];
                stage_mode[k] <= src_mode[k];
                stage_sign[k] <= src_sign[k];
            end
        end
    end
endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Bench for barrel_shift_pipe: an 8-bit and a 16-bit instance driven by
// directed and random streams, scored against a whole-shift reference.
module tb_barrel_shift_pipe;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    barrel_shift_pipe_if #(.WIDTH(8))  bus8();
    barrel_shift_pipe_if #(.WIDTH(16)) bus16();

    barrel_shift_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    barrel_shift_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    typedef struct {
        logic [31:0] exp_data;
        logic [31:0] lit_data;
        bit          has_lit;
        int          acc_cycle;
        int          acc_stalls;
    } beat_t;

    beat_t       q8[$];
    beat_t       q16[$];
    beat_t       b8;
    beat_t       b16;
    int          errors = 0;
    int          checks = 0;
    int          cycle = 0;
    int          stalls8 = 0;
    int          stalls16 = 0;
    logic [31:0] cur_lit8 = 0;
    logic [31:0] cur_lit16 = 0;
    bit          cur_has_lit8 = 0;
    bit          cur_has_lit16 = 0;
    bit          last_acc8 = 0;
    bit          last_acc16 = 0;
    bit          prev_stall8 = 0;
    bit          prev_stall16 = 0;
    logic [31:0] prev_data8 = 0;
    logic [31:0] prev_data16 = 0;

    logic [7:0] lsl_lits [8] = '{8'h81, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    // Whole-amount reference: shift the full operand by sha in one step.
    function automatic logic [31:0] ref_shift(input logic [31:0] d_in, input int sha,
                                              input logic dir, input logic [1:0] mode,
                                              input int w);
        logic [31:0] m;
        logic [31:0] d;
        m = (32'd1 << w) - 32'd1;
        d = d_in & m;
        if (sha == 0) return d;
        if (mode[1]) begin
            if (dir) return ((d >> sha) | (d << (w - sha))) & m;
            return ((d << sha) | (d >> (w - sha))) & m;
        end
        if (!dir) return (d << sha) & m;
        if (mode[0] && d[w-1]) return (d >> sha) | (m & ~(m >> sha));
        return d >> sha;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cycle);
        end
    endtask

    // Scoreboard: record accepted beats, check every delivered result,
    // its latency, in_ready and stall stability, once per cycle.
    always @(negedge clk) begin
        cycle++;
        if (!rst_n) begin
            q8.delete();
            q16.delete();
            prev_stall8  = 0;
            prev_stall16 = 0;
            last_acc8    = 0;
            last_acc16   = 0;
        end else begin
            checkOutput("in_ready8", 32'(bus8.in_ready), 32'(!(bus8.out_valid && !bus8.out_ready)));
            if (prev_stall8) begin
                checkOutput("stall_valid8", 32'(bus8.out_valid), 32'd1);
                checkOutput("stall_data8", 32'(bus8.out_data), prev_data8);
            end
            if (bus8.out_valid && bus8.out_ready) begin
                if (q8.size() == 0) begin
                    checkOutput("unexpected_beat8", 32'(q8.size()), 32'd1);
                end else begin
                    b8 = q8.pop_front();
                    checkOutput("data8", 32'(bus8.out_data), b8.exp_data);
                    checkOutput("zero8", 32'(bus8.out_zero), 32'(b8.exp_data == 0));
                    checkOutput("latency8", cycle, b8.acc_cycle + 3 + (stalls8 - b8.acc_stalls));
                    if (b8.has_lit) checkOutput("literal8", 32'(bus8.out_data), b8.lit_data);
                end
            end
            prev_stall8 = bus8.out_valid && !bus8.out_ready;
            if (prev_stall8) stalls8++;
            prev_data8 = 32'(bus8.out_data);
            last_acc8 = bus8.in_valid && bus8.in_ready;
            if (last_acc8) begin
                q8.push_back('{ref_shift(32'(bus8.in_data), int'(bus8.in_sha), bus8.in_dir,
                                         bus8.in_mode, 8),
                               cur_lit8, cur_has_lit8, cycle, stalls8});
            end

            checkOutput("in_ready16", 32'(bus16.in_ready), 32'(!(bus16.out_valid && !bus16.out_ready)));
            if (prev_stall16) begin
                checkOutput("stall_valid16", 32'(bus16.out_valid), 32'd1);
                checkOutput("stall_data16", 32'(bus16.out_data), prev_data16);
            end
            if (bus16.out_valid && bus16.out_ready) begin
                if (q16.size() == 0) begin
                    checkOutput("unexpected_beat16", 32'(q16.size()), 32'd1);
                end else begin
                    b16 = q16.pop_front();
                    checkOutput("data16", 32'(bus16.out_data), b16.exp_data);
                    checkOutput("zero16", 32'(bus16.out_zero), 32'(b16.exp_data == 0));
                    checkOutput("latency16", cycle, b16.acc_cycle + 4 + (stalls16 - b16.acc_stalls));
                    if (b16.has_lit) checkOutput("literal16", 32'(bus16.out_data), b16.lit_data);
                end
            end
            prev_stall16 = bus16.out_valid && !bus16.out_ready;
            if (prev_stall16) stalls16++;
            prev_data16 = 32'(bus16.out_data);
            last_acc16 = bus16.in_valid && bus16.in_ready;
            if (last_acc16) begin
                q16.push_back('{ref_shift(32'(bus16.in_data), int'(bus16.in_sha), bus16.in_dir,
                                          bus16.in_mode, 16),
                                cur_lit16, cur_has_lit16, cycle, stalls16});
            end
        end
    end

    task automatic applyStimulus8(input logic [7:0] data, input int sha, input logic dir,
                                  input logic [1:0] mode, input logic [7:0] lit, input bit has_lit);
        bit got;
        int n;
        got = 0;
        n = 0;
        bus8.in_data  = data;
        bus8.in_sha   = 3'(sha);
        bus8.in_dir   = dir;
        bus8.in_mode  = mode;
        bus8.in_valid = 1'b1;
        cur_lit8      = 32'(lit);
        cur_has_lit8  = has_lit;
        while (!got && n < 200) begin
            @(negedge clk);
            got = bus8.in_ready && rst_n;
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("accept_timeout8", 32'(got), 32'd1);
    endtask

    task automatic applyStimulus16(input logic [15:0] data, input int sha, input logic dir,
                                   input logic [1:0] mode, input logic [15:0] lit);
        bit got;
        int n;
        got = 0;
        n = 0;
        bus16.in_data  = data;
        bus16.in_sha   = 4'(sha);
        bus16.in_dir   = dir;
        bus16.in_mode  = mode;
        bus16.in_valid = 1'b1;
        cur_lit16      = 32'(lit);
        cur_has_lit16  = 1'b1;
        while (!got && n < 200) begin
            @(negedge clk);
            got = bus16.in_ready && rst_n;
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("accept_timeout16", 32'(got), 32'd1);
        bus16.in_valid = 1'b0;
        cur_has_lit16  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus8.in_valid  = 1'b0;
        bus16.in_valid = 1'b0;
        cur_has_lit8   = 1'b0;
        while ((q8.size() != 0 || q16.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_timeout", 32'(n < 300), 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus8.in_valid = 1'b0;  bus8.in_data = '0;  bus8.in_sha = '0;  bus8.in_dir = 1'b0;
        bus8.in_mode = 2'b00;  bus8.out_ready = 1'b1;
        bus16.in_valid = 1'b0; bus16.in_data = '0; bus16.in_sha = '0; bus16.in_dir = 1'b0;
        bus16.in_mode = 2'b00; bus16.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid8", 32'(bus8.out_valid), 32'd0);
        checkOutput("reset_out_data8", 32'(bus8.out_data), 32'd0);
        checkOutput("reset_out_zero8", 32'(bus8.out_zero), 32'd0);
        checkOutput("reset_in_ready8", 32'(bus8.in_ready), 32'd1);
        checkOutput("reset_out_valid16", 32'(bus16.out_valid), 32'd0);
        checkOutput("reset_out_data16", 32'(bus16.out_data), 32'd0);
        rst_n = 1'b1;

        checkOutput("model_lsl", ref_shift(32'h81, 1, 1'b0, 2'd0, 8), 32'h02);
        checkOutput("model_lsr", ref_shift(32'h81, 3, 1'b1, 2'd0, 8), 32'h10);
        checkOutput("model_asr", ref_shift(32'h81, 3, 1'b1, 2'd1, 8), 32'hF0);
        checkOutput("model_rol", ref_shift(32'h81, 4, 1'b0, 2'd2, 8), 32'h18);
        checkOutput("model_ror", ref_shift(32'h81, 1, 1'b1, 2'd3, 8), 32'hC0);
        checkOutput("model_asr16", ref_shift(32'h8001, 15, 1'b1, 2'd1, 16), 32'hFFFF);

        $display("[TB] logical left sweep");
        for (int s = 0; s < 8; s++) applyStimulus8(8'h81, s, 1'b0, 2'd0, lsl_lits[s], 1'b1);
        drain();

        $display("[TB] right shifts and rotates");
        applyStimulus8(8'h81, 3, 1'b1, 2'd0, 8'h10, 1'b1);
        applyStimulus8(8'h81, 3, 1'b1, 2'd1, 8'hF0, 1'b1);
        applyStimulus8(8'h41, 3, 1'b1, 2'd1, 8'h08, 1'b1);
        applyStimulus8(8'h80, 7, 1'b1, 2'd0, 8'h01, 1'b1);
        applyStimulus8(8'h01, 1, 1'b1, 2'd0, 8'h00, 1'b1);
        applyStimulus8(8'h81, 1, 1'b0, 2'd2, 8'h03, 1'b1);
        applyStimulus8(8'h81, 1, 1'b1, 2'd2, 8'hC0, 1'b1);
        applyStimulus8(8'h81, 4, 1'b0, 2'd2, 8'h18, 1'b1);
        applyStimulus8(8'h81, 1, 1'b1, 2'd3, 8'hC0, 1'b1);
        drain();

        $display("[TB] backpressure");
        fork
            begin
                for (int i = 0; i < 10; i++)
                    applyStimulus8(8'h01, i % 8, 1'b0, 2'd0, 8'(1 << (i % 8)), 1'b1);
                bus8.in_valid = 1'b0;
            end
            begin
                int n;
                n = 0;
                while (!bus8.out_valid && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                checkOutput("first_result_timeout", 32'(bus8.out_valid), 32'd1);
                bus8.out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                bus8.out_ready = 1'b1;
            end
        join
        drain();

        $display("[TB] reset mid-stream");
        applyStimulus8(8'h81, 1, 1'b0, 2'd0, 8'h00, 1'b0);
        applyStimulus8(8'h3C, 2, 1'b1, 2'd0, 8'h00, 1'b0);
        bus8.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midreset_out_valid", 32'(bus8.out_valid), 32'd0);
        checkOutput("midreset_out_data", 32'(bus8.out_data), 32'd0);
        checkOutput("midreset_out_zero", 32'(bus8.out_zero), 32'd0);
        rst_n = 1'b1;
        applyStimulus8(8'h81, 1, 1'b1, 2'd0, 8'h40, 1'b1);
        drain();

        $display("[TB] 16-bit instance");
        applyStimulus16(16'h8001, 15, 1'b1, 2'd1, 16'hFFFF);
        applyStimulus16(16'h8001, 8, 1'b0, 2'd2, 16'h0180);
        drain();

        $display("[TB] random streams");
        cur_has_lit8  = 1'b0;
        cur_has_lit16 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!bus8.in_valid || last_acc8) begin
                bus8.in_valid = ($urandom_range(0, 3) != 0);
                bus8.in_data  = 8'($urandom);
                bus8.in_sha   = 3'($urandom_range(0, 7));
                bus8.in_dir   = 1'($urandom_range(0, 1));
                bus8.in_mode  = 2'($urandom_range(0, 3));
            end
            if (!bus16.in_valid || last_acc16) begin
                bus16.in_valid = ($urandom_range(0, 3) != 0);
                bus16.in_data  = 16'($urandom);
                bus16.in_sha   = 4'($urandom_range(0, 15));
                bus16.in_dir   = 1'($urandom_range(0, 1));
                bus16.in_mode  = 2'($urandom_range(0, 3));
            end
            bus8.out_ready  = ($urandom_range(0, 3) != 0);
            bus16.out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end
        bus8.out_ready  = 1'b1;
        bus16.out_ready = 1'b1;
        drain();
        checkOutput("final_queue8", 32'(q8.size()), 32'd0);
        checkOutput("final_queue16", 32'(q16.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
